// File: rtl/aead_msg_sequencer_if.sv
// Valid/ready beat bundle with byte-enable keep mask.
// Used for upstream sources and for core-side AAD, payload and length streams.
interface aead_msg_sequencer_if #(
    parameter int BLK_BYTES = 16
);
    localparam int DATA_W = 8 * BLK_BYTES;

    logic                 valid;
    logic                 ready;
    logic [DATA_W-1:0]    data;
    logic [BLK_BYTES-1:0] keep;

    modport master (
        output valid,
        output data,
        output keep,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  keep,
        output ready
    );
endinterface

// File: rtl/aead_msg_sequencer.sv
// Sequences one AEAD message into the ChaCha20-Poly1305 core:
// config strobe, AAD beats, payload beats, length block, then final tag.
module aead_msg_sequencer #(
    parameter int BLK_BYTES = 16,
    parameter int LEN_W     = 32,
    parameter int WAIT_DONE = 1,
    parameter int TIMEOUT   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LEN_W-1:0]     aad_len,
    input  logic [LEN_W-1:0]     pld_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    aead_msg_sequencer_if.slave  s_aad,
    aead_msg_sequencer_if.slave  s_pld,
    output logic                 cfg_we,
    aead_msg_sequencer_if.master aad,
    aead_msg_sequencer_if.master pld,
    aead_msg_sequencer_if.master len,
    input  logic                 aad_done,
    input  logic                 pld_done,
    input  logic                 lens_done,
    input  logic [127:0]         tag_pre_xor,
    input  logic                 tag_pre_xor_valid,
    input  logic [127:0]         tagmask,
    input  logic                 tagmask_valid,
    output logic [127:0]         tag_out,
    output logic                 tag_valid,
    input  logic                 tag_ready
);
    localparam int DATA_W = 8 * BLK_BYTES;
    localparam int RW = LEN_W + 1;
    localparam bit WD = (WAIT_DONE != 0);
    localparam logic [RW-1:0] BLK = RW'(BLK_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_AAD, S_PLD, S_LEN, S_TAG, S_OUT, S_ERR
    } state_t;

    state_t state, state_n;
    logic [LEN_W-1:0] aad_len_q, pld_len_q;
    logic [RW-1:0] rem;
    logic wait_q, last_q;
    logic [127:0] pre_q, mask_q;
    logic pre_v, mask_v;
    logic [31:0] wd_cnt;

    logic in_aad, in_pld, last;
    logic hs_aad, hs_pld, hs_len, hs_tag;
    logic wd_hit, stall, clr;
    logic [BLK_BYTES-1:0] keep;
    logic [DATA_W-1:0] keep_bits, len_blk;

    assign in_aad = (state == S_AAD) && !wait_q;
    assign in_pld = (state == S_PLD) && !wait_q;
    assign last   = rem <= BLK;

    always_comb begin
        keep = '0;
        keep_bits = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            keep[i] = rem > RW'(i);
            keep_bits[8*i +: 8] = {8{keep[i]}};
        end
        len_blk = '0;
        len_blk[63:0]   = 64'(aad_len_q);
        len_blk[127:64] = 64'(pld_len_q);
    end

    assign aad.valid   = in_aad && s_aad.valid;
    assign s_aad.ready = in_aad && aad.ready;
    assign aad.keep    = in_aad ? keep : '0;
    assign aad.data    = in_aad ? (s_aad.data & keep_bits) : '0;

    assign pld.valid   = in_pld && s_pld.valid;
    assign s_pld.ready = in_pld && pld.ready;
    assign pld.keep    = in_pld ? keep : '0;
    assign pld.data    = in_pld ? (s_pld.data & keep_bits) : '0;

    assign len.valid = (state == S_LEN) && !wait_q;
    assign len.keep  = '0;
    assign len.data  = (state == S_LEN) ? len_blk : '0;

    assign hs_aad = aad.valid && aad.ready;
    assign hs_pld = pld.valid && pld.ready;
    assign hs_len = len.valid && len.ready;
    assign hs_tag = tag_valid && tag_ready;

    assign busy      = state != S_IDLE;
    assign err       = state == S_ERR;
    assign cfg_we    = state == S_CFG;
    assign tag_valid = state == S_OUT;
    assign done      = hs_tag;
    assign wd_hit    = (TIMEOUT > 0) && (wd_cnt >= 32'(TIMEOUT));

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = S_IDLE;
        end else if (wd_hit && state != S_IDLE && state != S_ERR) begin
            state_n = S_ERR;
        end else begin
            unique case (state)
                S_IDLE, S_ERR: if (start) state_n = S_CFG;
                S_CFG: state_n = (aad_len_q != '0) ? S_AAD :
                                 (pld_len_q != '0) ? S_PLD : S_LEN;
                S_AAD: if (wait_q ? (aad_done && last_q) : (hs_aad && last && !WD))
                    state_n = (pld_len_q != '0) ? S_PLD : S_LEN;
                S_PLD: if (wait_q ? (pld_done && last_q) : (hs_pld && last && !WD))
                    state_n = S_LEN;
                S_LEN: if (wait_q ? lens_done : (hs_len && !WD)) state_n = S_TAG;
                S_TAG: if (pre_v && mask_v) state_n = S_OUT;
                S_OUT: if (hs_tag) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Watchdog only advances while we are the ones waiting on the core.
    always_comb begin
        stall = 1'b0;
        unique case (state)
            S_AAD:   stall = wait_q || (aad.valid && !aad.ready);
            S_PLD:   stall = wait_q || (pld.valid && !pld.ready);
            S_LEN:   stall = wait_q || (len.valid && !len.ready);
            S_TAG:   stall = 1'b1;
            default: stall = 1'b0;
        endcase
        clr = hs_aad || hs_pld || hs_len || hs_tag
           || aad_done || pld_done || lens_done
           || (state_n != state)
           || (in_aad && !s_aad.valid) || (in_pld && !s_pld.valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            aad_len_q <= '0;
            pld_len_q <= '0;
            rem       <= '0;
            wait_q    <= 1'b0;
            last_q    <= 1'b0;
            pre_q     <= '0;
            mask_q    <= '0;
            pre_v     <= 1'b0;
            mask_v    <= 1'b0;
            tag_out   <= '0;
            wd_cnt    <= '0;
        end else begin
            state <= state_n;
            if (clr)
                wd_cnt <= '0;
            else if (stall && TIMEOUT > 0)
                wd_cnt <= wd_cnt + 32'd1;
            if ((state == S_IDLE || state == S_ERR) && start && !abort) begin
                aad_len_q <= aad_len;
                pld_len_q <= pld_len;
            end
            if (state_n != state) begin
                wait_q <= 1'b0;
                last_q <= 1'b0;
                if (state_n == S_AAD) rem <= {1'b0, aad_len_q};
                if (state_n == S_PLD) rem <= {1'b0, pld_len_q};
                if (state_n == S_OUT) tag_out <= pre_q ^ mask_q;
                if (state_n == S_CFG || state_n == S_IDLE) begin
                    pre_v  <= 1'b0;
                    mask_v <= 1'b0;
                end
            end else begin
                if (hs_aad || hs_pld) begin
                    if (!last) rem <= rem - BLK;
                    if (WD) begin
                        wait_q <= 1'b1;
                        last_q <= last;
                    end
                end
                if (hs_len && WD) wait_q <= 1'b1;
                if (wait_q && ((state == S_AAD && aad_done) ||
                               (state == S_PLD && pld_done)))
                    wait_q <= 1'b0;
            end
            // Tag halves may arrive in either order, so each latches alone.
            if (state == S_LEN || state == S_TAG) begin
                if (tag_pre_xor_valid && !pre_v) begin
                    pre_q <= tag_pre_xor;
                    pre_v <= 1'b1;
                end
                if (tagmask_valid && !mask_v) begin
                    mask_q <= tagmask;
                    mask_v <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aead_msg_sequencer.sv
// Scoreboard bench for aead_msg_sequencer with a small reactive core model.
// Expected beats, length blocks and tags are queued when stimulus is queued.
module tb_aead_msg_sequencer;
    localparam int BB = 16;
    localparam int DW = 8 * BB;
    localparam int LW = 32;
    localparam int TO = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [LW-1:0] aad_len = '0;
    logic [LW-1:0] pld_len = '0;
    logic busy, done, err, cfg_we;
    logic aad_done = 1'b0, pld_done = 1'b0, lens_done = 1'b0;
    logic [127:0] tag_pre_xor = '0, tagmask = '0, tag_out;
    logic tag_pre_xor_valid = 1'b0, tagmask_valid = 1'b0;
    logic tag_valid, tag_ready = 1'b0;

    aead_msg_sequencer_if #(.BLK_BYTES(BB)) s_aad_if ();
    aead_msg_sequencer_if #(.BLK_BYTES(BB)) s_pld_if ();
    aead_msg_sequencer_if #(.BLK_BYTES(BB)) aad_if ();
    aead_msg_sequencer_if #(.BLK_BYTES(BB)) pld_if ();
    aead_msg_sequencer_if #(.BLK_BYTES(BB)) len_if ();

    aead_msg_sequencer #(
        .BLK_BYTES(BB), .LEN_W(LW), .WAIT_DONE(1), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .aad_len(aad_len), .pld_len(pld_len),
        .busy(busy), .done(done), .err(err),
        .s_aad(s_aad_if), .s_pld(s_pld_if), .cfg_we(cfg_we),
        .aad(aad_if), .pld(pld_if), .len(len_if),
        .aad_done(aad_done), .pld_done(pld_done), .lens_done(lens_done),
        .tag_pre_xor(tag_pre_xor), .tag_pre_xor_valid(tag_pre_xor_valid),
        .tagmask(tagmask), .tagmask_valid(tagmask_valid),
        .tag_out(tag_out), .tag_valid(tag_valid), .tag_ready(tag_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]    src_aad[$], src_pld[$];
    logic [BB+DW-1:0] exp_aad[$], exp_pld[$];
    logic [127:0]     exp_len[$], exp_tag[$];

    bit h_saad, h_spld, h_aad, h_pld, h_len, h_tag;
    int n_aad, n_pld, n_len, n_done, n_cfg, n_aadv, tv_cnt;
    int hold, pre_dly, mask_dly, pre_cd, mask_cd;
    logic [127:0] pre_val, mask_val;
    bit core_rdy;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [BB+DW-1:0] mk_beat(input int r, input logic [DW-1:0] d);
        logic [BB-1:0] k;
        logic [DW-1:0] m;
        k = (r >= BB) ? '1 : BB'((17'd1 << r) - 17'd1);
        m = '0;
        for (int i = 0; i < BB; i++) m[8*i +: 8] = {8{k[i]}};
        return {k, d & m};
    endfunction

    // Monitor and scoreboard compare, away from the active edge.
    always @(negedge clk) begin
        logic [BB+DW-1:0] e;
        h_saad = s_aad_if.valid && s_aad_if.ready;
        h_spld = s_pld_if.valid && s_pld_if.ready;
        h_aad  = aad_if.valid && aad_if.ready;
        h_pld  = pld_if.valid && pld_if.ready;
        h_len  = len_if.valid && len_if.ready;
        h_tag  = tag_valid && tag_ready;
        if (aad_if.valid) n_aadv++;
        if (cfg_we) n_cfg++;
        if (h_aad) begin
            n_aad++;
            if (exp_aad.size() == 0) check("aad_extra", 1, 0);
            else begin
                e = exp_aad.pop_front();
                check("aad_keep", aad_if.keep, e[BB+DW-1:DW]);
                check("aad_data", aad_if.data, e[DW-1:0]);
            end
        end
        if (h_pld) begin
            n_pld++;
            if (exp_pld.size() == 0) check("pld_extra", 1, 0);
            else begin
                e = exp_pld.pop_front();
                check("pld_keep", pld_if.keep, e[BB+DW-1:DW]);
                check("pld_data", pld_if.data, e[DW-1:0]);
            end
        end
        if (h_len) begin
            n_len++;
            if (exp_len.size() == 0) check("len_extra", 1, 0);
            else check("len_block", len_if.data, exp_len.pop_front());
        end
        if (tag_valid && !tag_ready) begin
            tv_cnt++;
            if (exp_tag.size() > 0) check("tag_hold", tag_out, exp_tag[0]);
        end
        if (done || h_tag) check("done_pulse", done, h_tag);
        if (h_tag) begin
            n_done++;
            check("tag_wait", tv_cnt, hold);
            if (exp_tag.size() == 0) check("tag_extra", 1, 0);
            else check("tag_out", tag_out, exp_tag.pop_front());
        end
    end

    // Upstream sources and core model react just after each active edge.
    always @(posedge clk) begin
        logic [DW-1:0] tmp;
        #1;
        if (h_saad && src_aad.size() > 0) tmp = src_aad.pop_front();
        if (h_spld && src_pld.size() > 0) tmp = src_pld.pop_front();
        s_aad_if.valid = src_aad.size() > 0;
        s_aad_if.data  = (src_aad.size() > 0) ? src_aad[0] : '0;
        s_pld_if.valid = src_pld.size() > 0;
        s_pld_if.data  = (src_pld.size() > 0) ? src_pld[0] : '0;
        aad_done  = h_aad;
        pld_done  = h_pld;
        lens_done = h_len;
        aad_if.ready = core_rdy;
        pld_if.ready = core_rdy;
        len_if.ready = core_rdy;
        tag_pre_xor_valid = 1'b0;
        tagmask_valid = 1'b0;
        if (h_len) begin
            pre_cd  = pre_dly + 1;
            mask_cd = mask_dly + 1;
        end else begin
            if (pre_cd > 0) begin
                pre_cd--;
                if (pre_cd == 0) begin
                    tag_pre_xor_valid = 1'b1;
                    tag_pre_xor = pre_val;
                end
            end
            if (mask_cd > 0) begin
                mask_cd--;
                if (mask_cd == 0) begin
                    tagmask_valid = 1'b1;
                    tagmask = mask_val;
                end
            end
        end
        tag_ready = tv_cnt >= hold;
    end

    task automatic start_msg(input int alen, input int plen,
                             input int pd, input int md, input int hc);
        int r;
        logic [DW-1:0] d;
        pre_val  = rnd128();
        mask_val = rnd128();
        exp_tag.push_back(pre_val ^ mask_val);
        exp_len.push_back({64'(plen), 64'(alen)});
        r = alen;
        while (r > 0) begin
            d = rnd128();
            src_aad.push_back(d);
            exp_aad.push_back(mk_beat(r, d));
            r = (r > BB) ? r - BB : 0;
        end
        r = plen;
        while (r > 0) begin
            d = rnd128();
            src_pld.push_back(d);
            exp_pld.push_back(mk_beat(r, d));
            r = (r > BB) ? r - BB : 0;
        end
        n_aad = 0; n_pld = 0; n_len = 0; n_done = 0; n_cfg = 0; n_aadv = 0;
        tv_cnt = 0; hold = hc; pre_dly = pd; mask_dly = md;
        @(posedge clk); #1;
        start = 1'b1; aad_len = LW'(alen); pld_len = LW'(plen);
        @(posedge clk); #1;
        start = 1'b0; aad_len = ~LW'(alen); pld_len = ~LW'(plen);
        @(negedge clk);
        check("cfg_we", cfg_we, 1);
        check("err_clr", err, 0);
    endtask

    task automatic run_msg(input int alen, input int plen,
                           input int pd, input int md, input int hc);
        int c;
        start_msg(alen, plen, pd, md, hc);
        c = 0;
        while (n_done == 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        check("done_cnt", n_done, 1);
        check("cfg_cnt", n_cfg, 1);
        check("busy_end", busy, 0);
        check("aad_beats", n_aad, (alen + BB - 1) / BB);
        check("pld_beats", n_pld, (plen + BB - 1) / BB);
        check("len_beats", n_len, 1);
        check("q_left", exp_aad.size() + exp_pld.size() + exp_tag.size(), 0);
    endtask

    task automatic flush();
        src_aad.delete(); src_pld.delete();
        exp_aad.delete(); exp_pld.delete();
        exp_len.delete(); exp_tag.delete();
    endtask

    initial begin
        int c;
        s_aad_if.valid = 1'b0; s_aad_if.data = '0; s_aad_if.keep = '0;
        s_pld_if.valid = 1'b0; s_pld_if.data = '0; s_pld_if.keep = '0;
        aad_if.ready = 1'b0; pld_if.ready = 1'b0; len_if.ready = 1'b0;
        core_rdy = 1'b1; hold = 0; pre_cd = 0; mask_cd = 0;
        pre_dly = 0; mask_dly = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        check("rst_cfg", cfg_we, 0);
        check("rst_tagv", tag_valid, 0);
        check("rst_tag", tag_out, 0);
        check("rst_lenv", len_if.valid, 0);
        check("rst_lend", len_if.data, 0);
        check("rst_keep", aad_if.keep, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_msg(20, 33, 0, 0, 0);
        run_msg(0, 16, 1, 2, 0);
        check("no_aad_valid", n_aadv, 0);
        run_msg(0, 0, 1, 1, 0);
        run_msg(5, 40, 3, 0, 10);

        core_rdy = 1'b0;
        start_msg(32, 0, 0, 0, 0);
        c = 0;
        while (!err && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("wd_err", err, 1);
        check("wd_window", (c >= TO - 2 && c <= TO + 6), 1);
        check("err_busy", busy, 1);
        check("err_valid", aad_if.valid, 0);
        flush();
        core_rdy = 1'b1;
        run_msg(48, 7, 0, 0, 2);

        start_msg(0, 48, 0, 0, 0);
        c = 0;
        while (n_pld < 1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("pld_beat1", n_pld, 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_vld", {aad_if.valid, pld_if.valid, len_if.valid, tag_valid}, 0);
        flush();
        repeat (2) @(negedge clk);
        run_msg(17, 0, 0, 2, 1);

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("sa_busy", busy, 0);
        check("sa_cfg", cfg_we, 0);

        for (int i = 0; i < 3; i++)
            run_msg(int'($urandom_range(0, 70)), int'($urandom_range(0, 70)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
